// File: rtl/pfb_reorder_pkg.sv
// Shared types and the read-side index mapping for the PFB frame reorder buffer.
package pfb_reorder_pkg;

    // Ordering modes; the unused encoding 3 behaves like PASS.
    typedef enum logic [1:0] {
        PASS      = 2'd0,
        TRANSPOSE = 2'd1,
        FLIP      = 2'd2
    } mode_e;

    // Write-side framing states.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } wr_state_e;

    // Source sample index for lane m of output beat j in a frame of n samples on l lanes.
    function automatic int rd_index(input logic [1:0] mode, input int j, input int m,
                                    input int n, input int l);
        int d;
        d = n / l;
        case (mode)
            TRANSPOSE: return j + m * d;
            FLIP:      return n - 1 - (j * l + m);
            default:   return j * l + m;
        endcase
    endfunction

endpackage

// File: rtl/pfb_reorder.sv
// Two-bank ping-pong frame reorder buffer with tlast framing, selectable
// output ordering and AXI-Stream backpressure on both sides.
module pfb_reorder
    import pfb_reorder_pkg::*;
#(
    parameter int N = 64,
    parameter int L = 4,
    parameter int B = 32
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [L*B-1:0] s_axis_tdata,
    input  logic           s_axis_tlast,
    input  logic           s_axis_tvalid,
    output logic           s_axis_tready,
    output logic [L*B-1:0] m_axis_tdata,
    output logic           m_axis_tlast,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,
    input  logic [1:0]     MODE_REG,
    output logic           sync_ok,
    output logic [15:0]    err_cnt
);

    localparam int D  = N / L;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(D);
    localparam logic [CW-1:0] LAST_ROW = CW'(D - 1);

    logic [B-1:0]  mem [2][N];
    logic [1:0]    full;
    logic [1:0]    bank_mode [2];
    wr_state_e     state, state_next;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic          wr_bank, rd_bank;
    logic          accept, wr_en, frame_done, frame_err;
    logic          rd_load, rd_done;

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign s_axis_tready = !areset && ((state == SYNC) || !full[wr_bank]);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign wr_en         = accept && (state == RUN);
    assign sync_ok       = (state == RUN);

    // Write FSM state register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= SYNC;
        else        state <= state_next;
    end

    // Next state plus the frame-complete / framing-error strobes.
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state)
            SYNC: begin
                if (accept && s_axis_tlast) state_next = RUN;
            end
            RUN: begin
                if (accept) begin
                    if (wr_cnt == LAST_ROW) begin
                        if (s_axis_tlast) begin
                            frame_done = 1'b1;
                        end else begin
                            frame_err  = 1'b1;
                            state_next = SYNC;
                        end
                    end else if (s_axis_tlast) begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: state_next = SYNC;
        endcase
    end

    // Write row counter, write bank pointer, per-bank mode latch and error counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_cnt       <= '0;
            wr_bank      <= 1'b0;
            bank_mode[0] <= '0;
            bank_mode[1] <= '0;
            err_cnt      <= '0;
        end else begin
            if (wr_en && (wr_cnt == '0)) bank_mode[wr_bank] <= MODE_REG;
            if (wr_en) begin
                if (frame_done || frame_err) wr_cnt <= '0;
                else                         wr_cnt <= wr_cnt + CW'(1);
            end
            if (frame_done) wr_bank <= !wr_bank;
            if (frame_err && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end

    // Sample storage; contents need no reset because the full flags gate all reads.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int l = 0; l < L; l++) begin
                mem[wr_bank][IW'(int'(wr_cnt) * L + l)] <= s_axis_tdata[l*B +: B];
            end
        end
    end

    // Bank full flags: set by a completed frame, cleared once its last beat is read.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            full <= '0;
        end else begin
            if (frame_done) full[wr_bank] <= 1'b1;
            if (rd_done)    full[rd_bank] <= 1'b0;
        end
    end

    assign rd_load = (!m_axis_tvalid || m_axis_tready) && full[rd_bank];
    assign rd_done = rd_load && (rd_cnt == LAST_ROW);

    // Output register stage: gathers one reordered beat per load, holds it under backpressure.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            rd_cnt        <= '0;
            rd_bank       <= 1'b0;
        end else if (rd_load) begin
            for (int m = 0; m < L; m++) begin
                m_axis_tdata[m*B +: B] <=
                    mem[rd_bank][IW'(rd_index(bank_mode[rd_bank], int'(rd_cnt), m, N, L))];
            end
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (rd_cnt == LAST_ROW);
            if (rd_cnt == LAST_ROW) begin
                rd_cnt  <= '0;
                rd_bank <= !rd_bank;
            end else begin
                rd_cnt <= rd_cnt + CW'(1);
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
